register_serializer: RTL and testbench

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer.sv | 134 +++++++++++++
 tb/tb_register_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/register_serializer.sv
// register_serializer
//   Captures a WIDTH-bit word and shifts it out on sout MSB first, one bit per
//   clock, then pulses done for one cycle before returning to idle.
//
//   Optional feature: define REGISTER_SERIALIZER_PARITY_EN to append an
//   even-parity bit (XOR of the captured word) as an extra frame bit.
//
// Ports
//   clk        in   clock, rising edge
//   rst_       in   synchronous active-high reset
//   data       in   [WIDTH-1:0] parallel word, captured when load & ready
//   load       in   capture request, ignored unless ready
//   ready      out  block idle, can accept a word
//   sout       out  serial bit (0 whenever sout_valid is low)
//   sout_valid out  sout carries a frame bit
//   done       out  one-cycle pulse after the last frame bit
module register_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef REGISTER_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
`ifdef REGISTER_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef REGISTER_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d  = data;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef REGISTER_SERIALIZER_PARITY_EN
          parity_d = ^data;
`endif
        end
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        // Counter holds on the last bit so it never wraps within a frame.
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are computed from the next state.
    ready_d      = (state_d == IDLE);
    sout_valid_d = (state_d == SHIFT);
    done_d       = (state_d == DONE);
    sout_d       = sout_valid_d & shift_d[WIDTH-1];
`ifdef REGISTER_SERIALIZER_PARITY_EN
    if (sout_valid_d && (cnt_d == CW'(WIDTH))) begin
      sout_d = parity_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGISTER_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
`ifdef REGISTER_SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_register_serializer.sv
// Testbench for register_serializer (WIDTH = 8).
// Outputs are compared as the tuple {ready, sout_valid, sout, done}.
// Honors REGISTER_SERIALIZER_PARITY_EN when defined for the whole build.
module tb_register_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef REGISTER_SERIALIZER_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif

  localparam logic [3:0] IDLE_O = 4'b1000;
  localparam logic [3:0] DONE_O = 4'b0001;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic [WIDTH-1:0] data = '0;
  logic             load = 1'b0;
  logic             ready, sout, sout_valid, done;

  int checks = 0;
  int errors = 0;

  register_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .data       (data),
    .load       (load),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of the output tuples expected after each
  // upcoming edge. Empty queue means idle.
  logic [3:0] model_q[$];

  function automatic logic [3:0] model_out();
    return (model_q.size() == 0) ? IDLE_O : model_q[0];
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [WIDTH-1:0] d);
    if (r) begin
      model_q.delete();
    end else if (model_q.size() == 0) begin
      if (l) begin
        for (int i = 0; i < int'(WIDTH); i++) model_q.push_back({2'b01, d[WIDTH-1-i], 1'b0});
        if (FL > WIDTH) model_q.push_back({2'b01, ^d, 1'b0});
        model_q.push_back(DONE_O);
      end
    end else begin
      void'(model_q.pop_front());
    end
  endtask

  function automatic logic [3:0] outs();
    return {ready, sout_valid, sout, done};
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got r/v/s/d=%b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic r, input logic l, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst_ = r;
    load = l;
    data = d;
    @(posedge clk);
    model_edge(r, l, d);
    #1;
  endtask

  typedef struct {
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [3:0]       exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic [WIDTH-1:0] d,
                     input logic [3:0] e, input string n);
    vec_t v;
    v.rst = r; v.load = l; v.data = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // One frame: capture row, remaining bit rows (with optional ignored load),
  // done row and a trailing idle row.
  task automatic add_frame(input logic [WIDTH-1:0] d, input logic busy_load,
                           input logic [WIDTH-1:0] busy_data, input string n);
    add(1'b0, 1'b1, d, {2'b01, d[WIDTH-1], 1'b0}, {n, "_bit0"});
    for (int i = 1; i < int'(WIDTH); i++)
      add(1'b0, busy_load, busy_data, {2'b01, d[WIDTH-1-i], 1'b0}, $sformatf("%s_bit%0d", n, i));
    if (FL > WIDTH) add(1'b0, busy_load, busy_data, {2'b01, ^d, 1'b0}, {n, "_parity"});
    add(1'b0, busy_load, busy_data, DONE_O, {n, "_done"});
    add(1'b0, 1'b0, busy_data, IDLE_O, {n, "_ready"});
  endtask

  initial begin
    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] aa;
    f0 = 8'hF0;
    aa = 8'hAA;

    add(1'b1, 1'b0, 8'h00, IDLE_O, "reset");
    add_frame(8'h55, 1'b0, 8'h00, "f55");
    add_frame(8'hAA, 1'b1, 8'hCC, "faa_loadcc");
    add_frame(8'h07, 1'b0, 8'h00, "f07");
    add(1'b1, 1'b1, 8'hFF, IDLE_O, "rst_beats_load");
    add(1'b0, 1'b0, 8'hFF, IDLE_O, "rst_beats_load_after");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].data);
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // Load held high: frames repeat with a DONE and an IDLE cycle between.
    step(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 3 * (int'(FL) + 2); c++) begin
      int k;
      logic [3:0] e;
      step(1'b0, 1'b1, f0);
      k = c % (int'(FL) + 2);
      if (k < int'(WIDTH))      e = {2'b01, f0[WIDTH-1-k], 1'b0};
      else if (k < int'(FL))    e = {2'b01, ^f0, 1'b0};
      else if (k == int'(FL))   e = DONE_O;
      else                      e = IDLE_O;
      chk($sformatf("b2b_c%0d", c), outs(), e);
    end

    // Reset while the 4th bit of an AA frame is on sout: frame aborted, no done.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, aa);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("midframe_bit3", outs(), {2'b01, aa[WIDTH-4], 1'b0});
    step(1'b1, 1'b0, 8'h00);
    chk("midframe_reset", outs(), IDLE_O);
    for (int c = 0; c < int'(FL) + 2; c++) begin
      step(1'b0, 1'b0, 8'h00);
      chk($sformatf("midframe_nodone%0d", c), outs(), IDLE_O);
    end

    // Random stimulus against the reference model.
    step(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      logic r, l;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 39) == 0);
      l = $urandom_range(0, 1) == 1;
      d = WIDTH'($urandom);
      step(r, l, d);
      chk("random", outs(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
